sram_port_ctrl: RTL and testbench
=================================

# sram_port_ctrl

Initiator-side controller for the single-port RW SRAM macros (one shared `addr`/`en`/`wmode` port, 1-cycle registered read, garbage rdata on non-read cycles). Merges independent read and write request streams onto the single port with fair arbitration. Optionally zero-clears the whole array after reset. Returns read data one cycle after acceptance and holds it stable until the next read completes. Sits between a pipeline table (predictor/tag array) and its `array_*_ext` macro.

## Interface
Parameters:
- `ADDR_W`, 11, SRAM address width
- `DATA_W`, 5, SRAM data width
- `DEPTH`, 2048, number of entries; must be ≤ 2^ADDR_W
- `CLEAR_ON_RESET`, 1, 1 = sweep-write zero to all entries after reset

Ports:
- `clock`  in  1  sole clock; SRAM macro `RW0_clk` is tied to it
- `reset`  in  1  synchronous, active-high
- `w_req_valid`  in  1  write request
- `w_req_ready`  out  1  write accepted when valid&&ready
- `w_req_addr`  in  ADDR_W  write address
- `w_req_data`  in  DATA_W  write data
- `r_req_valid`  in  1  read request
- `r_req_ready`  out  1  read accepted when valid&&ready
- `r_req_addr`  in  ADDR_W  read address
- `r_resp_valid`  out  1  pulses one cycle after an accepted read
- `r_resp_data`  out  DATA_W  read data; held between reads
- `init_done`  out  1  clear sweep finished, requests may be accepted
- `mem_en`, `mem_wmode`  out  1 each  to `RW0_en`, `RW0_wmode`
- `mem_addr`  out  ADDR_W  to `RW0_addr`
- `mem_wdata`  out  DATA_W  to `RW0_wdata`
- `mem_rdata`  in  DATA_W  from `RW0_rdata`

## Operation
- FSM states:
  - CLEAR: `mem_en=1`, `mem_wmode=1`, `mem_wdata=0`, `mem_addr=clr_cnt`; `clr_cnt` increments each cycle. At `clr_cnt==DEPTH-1` → RUN.
  - RUN: normal arbitration.
- Reset enters CLEAR with `clr_cnt=0` if `CLEAR_ON_RESET=1`, else enters RUN directly.
- `init_done = (state==RUN)`. Both readies are forced 0 outside RUN.
- Arbitration in RUN:
  - Only one valid: that request is granted.
  - Both valid: the side selected by `prio_w` is granted. `prio_w` resets to 1 (write first) and toggles only on contention cycles.
  - `w_req_ready = init_done && (!r_req_valid || prio_w)`
  - `r_req_ready = init_done && (!w_req_valid || !prio_w)`
  - Ready depends combinationally on the opposite valid and never on its own valid.
- Grant drives the port in the same cycle:
  - Write: `mem_en=1`, `mem_wmode=1`, addr and data from the request.
  - Read: `mem_en=1`, `mem_wmode=0`, `mem_addr=r_req_addr`.
  - Idle: `mem_en=0`, `mem_addr`/`mem_wdata` = 0.
- Response path:
  - `resp_pend` register is set by read acceptance.
  - `r_resp_valid = resp_pend`.
  - `r_resp_data = resp_pend ? mem_rdata : hold_q`.
  - `hold_q <= mem_rdata` when `resp_pend`.
  - No response backpressure.
- Read-after-write to the same address in the next cycle returns the new data (macro semantics). Read and write in the same cycle cannot occur.
- Reset mid-operation: any pending response is dropped (`r_resp_valid=0` next cycle) and the sweep restarts at address 0. Writes in flight before reset are not guaranteed to survive, because the clear overwrites them.

## Timing
- Reset values: `r_resp_valid=0`, `r_resp_data=0` (`hold_q=0`), `init_done=0` (1 if `CLEAR_ON_RESET=0`), both readies 0, `mem_en=0` while `reset` is high.
- Clear sweep: first cycle after reset deassertion writes addr 0. `init_done` rises exactly `DEPTH` cycles after deassertion.
- Request acceptance and the SRAM access happen in the same cycle.
- Read latency is 1 cycle: accept at cycle N → `r_resp_valid` at N+1 with `mem_rdata`.
- Back-to-back reads are supported: one read per cycle, one response per cycle.
- Sustained contention gives strict write/read alternation: each side receives ≥50% of cycles.
- `r_resp_data` is stable on every cycle without `r_resp_valid`.

## Structure
- Package `sram_ctrl_pkg`: state enum (`CLEAR`, `RUN`) and grant-select encoding (`GNT_NONE`, `GNT_W`, `GNT_R`).
- One natural sub-module, `sram_clear_seq`: owns `clr_cnt`, its terminal-count compare, and `done`. Arbitration, hold register and port mux stay in the top.
- Width rule: `clr_cnt` is `ADDR_W+1` bits so `DEPTH=2^ADDR_W` terminates without wrap.

## Test plan
- Reset with `CLEAR_ON_RESET=1`, DEPTH=2048 → `mem_en&&mem_wmode` for 2048 cycles, addr 0..2047, data 0. `init_done` rises on cycle 2048. Then read addr 0x7FF → resp data 0.
- Write addr 0x012 data 0x15, then read 0x012 next cycle → `r_resp_valid` one cycle after read accept with data 0x15. Afterwards `r_resp_data` stays 0x15 for 10 idle cycles while the macro returns random data.
- Both valid for 6 cycles → grants W,R,W,R,W,R. `mem_wmode` pattern 1,0,1,0,1,0. Three responses are returned.
- Back-to-back reads of 0x001..0x004 (preloaded 1..4) → `r_resp_valid` high for 4 consecutive cycles with data 1,2,3,4.
- Assert reset at sweep address 0x300 → sweep restarts at 0. `init_done` rises 2048 cycles after the new deassertion. A read accepted the cycle before reset produces no `r_resp_valid`.
- `CLEAR_ON_RESET=0` → `init_done=1` on the first cycle after reset. A write is accepted that cycle.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM port controller: FSM states and grant selection.
package sram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_W    = 2'd1,
        GNT_R    = 2'd2
    } gnt_t;

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sweep address generator for a single-port SRAM macro.
// The counter is one bit wider than the address so DEPTH == 2**ADDR_W
// reaches its terminal count without wrapping back to zero.
module sram_clear_seq
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              active,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    logic [ADDR_W:0] clr_cnt;

    // Sweep counter: restarts at address 0 on every reset, advances once per sweep cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (active) begin
            clr_cnt <= clr_cnt + ONE;
        end
    end

    // Current sweep address and terminal-count flag for the last write of the sweep
    always_comb begin
        clr_addr = clr_cnt[ADDR_W-1:0];
        done     = active && (clr_cnt == LAST);
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a single-port RW SRAM macro. Merges a read
// and a write request stream onto the one port with alternating priority on
// contention, optionally zero-clears the array after reset, and returns read
// data one cycle after acceptance, holding it stable between reads.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 5,
    parameter int DEPTH          = 2048,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,

    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,

    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,

    output logic              init_done,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t            state;
    state_t            state_nx;
    gnt_t              gnt;
    logic              run_ok;
    logic              prio_w;
    logic              resp_pend;
    logic              resp_vis;
    logic [DATA_W-1:0] hold_q;
    logic              clr_active;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;

    sram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .active   (clr_active),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );

    // Sweep runs only in CLEAR and never while reset is held
    always_comb begin
        clr_active = (state == CLEAR) && !reset;
    end

    // State register: reset re-enters the sweep (or goes straight to RUN without clearing)
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave CLEAR after the last sweep write, RUN is terminal until reset
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_done) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = RST_STATE;
        endcase
    end

    // Outputs: readies, grant select and the SRAM port mux
    always_comb begin
        init_done   = (state == RUN);
        run_ok      = init_done && !reset;
        // each ready looks only at the opposite valid, never at its own
        w_req_ready = run_ok && (!r_req_valid || prio_w);
        r_req_ready = run_ok && (!w_req_valid || !prio_w);

        gnt = GNT_NONE;
        if (w_req_valid && w_req_ready) begin
            gnt = GNT_W;
        end else if (r_req_valid && r_req_ready) begin
            gnt = GNT_R;
        end

        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_en    = 1'b1;
                mem_wmode = 1'b1;
                mem_addr  = clr_addr;
            end else begin
                case (gnt)
                    GNT_W: begin
                        mem_en    = 1'b1;
                        mem_wmode = 1'b1;
                        mem_addr  = w_req_addr;
                        mem_wdata = w_req_data;
                    end
                    GNT_R: begin
                        mem_en    = 1'b1;
                        mem_wmode = 1'b0;
                        mem_addr  = r_req_addr;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Priority toggles only on contention; response flag and hold register track accepted reads
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_w    <= 1'b1;
            resp_pend <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (run_ok && w_req_valid && r_req_valid) begin
                prio_w <= !prio_w;
            end
            resp_pend <= (gnt == GNT_R);
            if (resp_pend) begin
                hold_q <= mem_rdata;
            end
        end
    end

    // Response: a read accepted just before reset is suppressed while reset is high,
    // so the dropped response never becomes visible
    always_comb begin
        resp_vis     = resp_pend && !reset;
        r_resp_valid = resp_vis;
        r_resp_data  = resp_vis ? mem_rdata : hold_q;
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl with a behavioural SRAM macro.
module tb_sram_port_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 2048;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic              w_req_valid, w_req_ready;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              r_req_valid, r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              init_done;
    logic              mem_en, mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic              b_reset;
    logic              b_w_req_valid, b_w_req_ready;
    logic [ADDR_W-1:0] b_w_req_addr;
    logic [DATA_W-1:0] b_w_req_data;
    logic              b_r_req_valid, b_r_req_ready;
    logic [ADDR_W-1:0] b_r_req_addr;
    logic              b_r_resp_valid;
    logic [DATA_W-1:0] b_r_resp_data;
    logic              b_init_done;
    logic              b_mem_en, b_mem_wmode;
    logic [ADDR_W-1:0] b_mem_addr;
    logic [DATA_W-1:0] b_mem_wdata, b_mem_rdata;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    sram_port_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .w_req_valid  (w_req_valid),
        .w_req_ready  (w_req_ready),
        .w_req_addr   (w_req_addr),
        .w_req_data   (w_req_data),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .init_done    (init_done),
        .mem_en       (mem_en),
        .mem_wmode    (mem_wmode),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    sram_port_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b0)
    ) dut_noclr (
        .clock        (clock),
        .reset        (b_reset),
        .w_req_valid  (b_w_req_valid),
        .w_req_ready  (b_w_req_ready),
        .w_req_addr   (b_w_req_addr),
        .w_req_data   (b_w_req_data),
        .r_req_valid  (b_r_req_valid),
        .r_req_ready  (b_r_req_ready),
        .r_req_addr   (b_r_req_addr),
        .r_resp_valid (b_r_resp_valid),
        .r_resp_data  (b_r_resp_data),
        .init_done    (b_init_done),
        .mem_en       (b_mem_en),
        .mem_wmode    (b_mem_wmode),
        .mem_addr     (b_mem_addr),
        .mem_wdata    (b_mem_wdata),
        .mem_rdata    (b_mem_rdata)
    );

    assign b_mem_rdata = 5'h0A;

    // Behavioural single-port macro: registered read, garbage rdata on non-read cycles.
    // Contents start nonzero so the clear sweep is observable.
    logic [DATA_W-1:0] sram [0:DEPTH-1];
    logic              filled = 1'b0;

    always @(posedge clock) begin
        if (!filled) begin
            for (int i = 0; i < DEPTH; i++) sram[i] = DATA_W'((i % 31) + 1);
            filled = 1'b1;
        end
        if (mem_en && mem_wmode) sram[mem_addr] = mem_wdata;
        if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
        else                      mem_rdata <= DATA_W'($urandom);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks one clear write per cycle for addresses 0..last_i; caller has just released reset
    task automatic sweep(input int unsigned last_i);
        for (int unsigned i = 0; i <= last_i; i++) begin
            if (i != 0) @(negedge clock);
            #1;
            chk_eq($sformatf("sweep@%0h", i),
                   32'({mem_en, mem_wmode, init_done, mem_wdata, mem_addr}),
                   32'({1'b1, 1'b1, 1'b0, 5'd0, 11'(i)}));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        w_req_valid = 1'b0; w_req_addr = '0; w_req_data = '0;
        r_req_valid = 1'b0; r_req_addr = '0;
        b_reset = 1'b1;
        b_w_req_valid = 1'b0; b_w_req_addr = '0; b_w_req_data = '0;
        b_r_req_valid = 1'b0; b_r_req_addr = '0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk_eq("rst_mem_en", 32'(mem_en), 0);
        chk_eq("rst_resp", 32'({r_resp_valid, r_resp_data}), 0);
        chk_eq("rst_init_done", 32'(init_done), 0);
        chk_eq("rst_readies", 32'({w_req_ready, r_req_ready}), 0);
        chk_eq("rst_b_init_done", 32'(b_init_done), 1);
        chk_eq("rst_b_w_ready", 32'(b_w_req_ready), 0);

        // Full clear sweep, then read the top address
        @(negedge clock);
        reset = 1'b0;
        sweep(DEPTH - 1);
        @(negedge clock);
        r_req_valid = 1'b1; r_req_addr = 11'h7FF;
        #1;
        chk_eq("init_done_rise", 32'(init_done), 1);
        chk_eq("rd7ff_ready", 32'(r_req_ready), 1);
        chk_eq("rd7ff_port", 32'({mem_en, mem_wmode, mem_addr}), 32'({1'b1, 1'b0, 11'h7FF}));
        @(negedge clock);
        r_req_valid = 1'b0;
        #1;
        chk_eq("rd7ff_resp", 32'({r_resp_valid, r_resp_data}), 32'({1'b1, 5'h00}));

        // Write then read-after-write, then hold across idle cycles
        @(negedge clock);
        w_req_valid = 1'b1; w_req_addr = 11'h012; w_req_data = 5'h15;
        #1;
        chk_eq("wr12_ready", 32'(w_req_ready), 1);
        chk_eq("wr12_port", 32'({mem_en, mem_wmode, mem_addr, mem_wdata}),
               32'({1'b1, 1'b1, 11'h012, 5'h15}));
        chk_eq("wr12_noresp", 32'(r_resp_valid), 0);
        @(negedge clock);
        w_req_valid = 1'b0;
        r_req_valid = 1'b1; r_req_addr = 11'h012;
        #1;
        chk_eq("rd12_ready", 32'(r_req_ready), 1);
        chk_eq("rd12_port", 32'({mem_en, mem_wmode, mem_addr}), 32'({1'b1, 1'b0, 11'h012}));
        @(negedge clock);
        r_req_valid = 1'b0;
        #1;
        chk_eq("rd12_resp", 32'({r_resp_valid, r_resp_data}), 32'({1'b1, 5'h15}));
        chk_eq("idle_port", 32'({mem_en, mem_addr, mem_wdata}), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            chk_eq($sformatf("hold_%0d", i), 32'({r_resp_valid, r_resp_data}), 32'({1'b0, 5'h15}));
        end

        // Contention: both streams valid for 6 cycles, grants alternate W,R,W,R,W,R
        for (int k = 0; k < 6; k++) begin
            int wi, ri, exp_data;
            bit even;
            @(negedge clock);
            wi = (k + 1) / 2;
            ri = k / 2;
            even = (k % 2 == 0);
            w_req_valid = 1'b1; w_req_addr = 11'(32'h40 + wi); w_req_data = 5'(32'h11 + wi);
            r_req_valid = 1'b1; r_req_addr = 11'(32'h40 + ri);
            #1;
            chk_eq($sformatf("cont_rdy_%0d", k), 32'({w_req_ready, r_req_ready}),
                   even ? 32'h2 : 32'h1);
            chk_eq($sformatf("cont_port_%0d", k), 32'({mem_en, mem_wmode, mem_addr}),
                   32'({1'b1, even, 11'(32'h40 + (even ? wi : ri))}));
            if (k < 2)  exp_data = 'h15;
            else if (even) exp_data = 'h11 + (k - 1) / 2;
            else exp_data = 'h11 + (k - 3) / 2;
            chk_eq($sformatf("cont_resp_%0d", k), 32'({r_resp_valid, r_resp_data}),
                   32'({(even && k >= 2), 5'(exp_data)}));
        end
        @(negedge clock);
        w_req_valid = 1'b0; r_req_valid = 1'b0;
        #1;
        chk_eq("cont_resp_6", 32'({r_resp_valid, r_resp_data}), 32'({1'b1, 5'h13}));
        chk_eq("cont_idle", 32'(mem_en), 0);

        // Preload 1..4 at addresses 1..4, then back-to-back reads
        for (int j = 1; j <= 4; j++) begin
            @(negedge clock);
            w_req_valid = 1'b1; w_req_addr = 11'(j); w_req_data = 5'(j);
            #1;
            chk_eq($sformatf("pre_wr_%0d", j), 32'({w_req_ready, mem_en, mem_wmode}), 32'h7);
        end
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            w_req_valid = 1'b0;
            r_req_valid = (j <= 4);
            r_req_addr = 11'(j);
            #1;
            if (j <= 4) chk_eq($sformatf("b2b_rdy_%0d", j), 32'(r_req_ready), 1);
            if (j == 1) chk_eq("b2b_resp_1", 32'({r_resp_valid, r_resp_data}), 32'({1'b0, 5'h13}));
            else chk_eq($sformatf("b2b_resp_%0d", j), 32'({r_resp_valid, r_resp_data}),
                        32'({1'b1, 5'(j - 1)}));
        end
        @(negedge clock);
        r_req_valid = 1'b0;
        #1;
        chk_eq("b2b_hold", 32'({r_resp_valid, r_resp_data}), 32'({1'b0, 5'h04}));

        // Read accepted the cycle before reset is dropped
        @(negedge clock);
        r_req_valid = 1'b1; r_req_addr = 11'h001;
        #1;
        chk_eq("pre_rst_rd_rdy", 32'(r_req_ready), 1);
        @(negedge clock);
        r_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_eq("rst_drop_a", 32'(r_resp_valid), 0);
        chk_eq("rst_mem_en_a", 32'(mem_en), 0);
        @(negedge clock);
        #1;
        chk_eq("rst_drop_b", 32'({r_resp_valid, r_resp_data}), 0);
        chk_eq("rst_init_b", 32'({init_done, mem_en}), 0);

        // Sweep interrupted at 0x300 restarts from 0
        @(negedge clock);
        reset = 1'b0;
        sweep(32'h300);
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_en", 32'(mem_en), 0);
        @(negedge clock);
        #1;
        chk_eq("mid_rst_state", 32'({init_done, mem_en}), 0);
        @(negedge clock);
        reset = 1'b0;
        sweep(DEPTH - 1);
        @(negedge clock);
        r_req_valid = 1'b1; r_req_addr = 11'h001;
        #1;
        chk_eq("re_init_done", 32'({init_done, r_req_ready}), 32'h3);
        @(negedge clock);
        r_req_valid = 1'b0;
        #1;
        chk_eq("re_clr_rd1", 32'({r_resp_valid, r_resp_data}), 32'({1'b1, 5'h00}));

        // No-clear instance: ready on the first cycle after reset
        @(negedge clock);
        b_reset = 1'b0;
        b_w_req_valid = 1'b1; b_w_req_addr = 11'h005; b_w_req_data = 5'h07;
        #1;
        chk_eq("nc_init_done", 32'(b_init_done), 1);
        chk_eq("nc_readies", 32'({b_w_req_ready, b_r_req_ready}), 32'h2);
        chk_eq("nc_port", 32'({b_mem_en, b_mem_wmode, b_mem_addr, b_mem_wdata}),
               32'({1'b1, 1'b1, 11'h005, 5'h07}));
        chk_eq("nc_resp", 32'({b_r_resp_valid, b_r_resp_data}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
